// File: rtl/spi_pkg.sv
// Shared types and elaboration helpers for the parametrised SPI master.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_CS_IDLE
  } spi_state_t;

  // SCLK idle level: bit 1 of the mode number.
  function automatic logic spi_cpol(input int mode);
    return (mode / 2) % 2 == 1;
  endfunction

  // Clock phase: bit 0 of the mode number.
  function automatic logic spi_cpha(input int mode);
    return mode % 2 == 1;
  endfunction

  // Width of the chip-select index: max(1, clog2(num_cs)).
  function automatic int cs_width(input int num_cs);
    return (num_cs <= 2) ? 1 : $clog2(num_cs);
  endfunction

  // Width of a counter that runs 0 .. n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // True when every parameter is inside its legal range.
  function automatic bit params_ok(input int data_w, input int spi_mode,
                                   input int clks_per_half_bit, input int num_cs,
                                   input int setup_clks, input int hold_clks,
                                   input int idle_clks);
    return (data_w >= 1) && (data_w <= 32) &&
           (spi_mode >= 0) && (spi_mode <= 3) &&
           (clks_per_half_bit >= 2) && (num_cs >= 1) &&
           (setup_clks >= 1) && (hold_clks >= 1) && (idle_clks >= 1);
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: while enabled, toggles SCLK every CLKS_PER_HALF_BIT cycles
// for exactly 2*DATA_W edges and flags leading/trailing/final edges one cycle
// ahead of the visible SCLK change, so the parent can act on the same edge.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int DATA_W            = 12,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic cpol,
  output logic sclk,
  output logic lead_edge,
  output logic trail_edge,
  output logic done
);

  localparam int HALF_W = cnt_width(CLKS_PER_HALF_BIT);
  localparam int EDGE_W = cnt_width(2 * DATA_W);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

  logic [HALF_W-1:0] half_cnt_reg;
  logic [EDGE_W-1:0] edge_cnt_reg;
  logic              toggle_reg;
  logic              edge_stb;

  // An edge happens at the end of the last cycle of each half period.
  assign edge_stb   = enable && (half_cnt_reg == HALF_LAST);
  // Even-numbered edges leave the idle level (leading), odd ones return to it.
  assign lead_edge  = edge_stb && !edge_cnt_reg[0];
  assign trail_edge = edge_stb && edge_cnt_reg[0];
  assign done       = edge_stb && (edge_cnt_reg == EDGE_LAST);
  // SCLK is the idle level XOR a reset-to-zero toggle, so reset needs no data input.
  assign sclk       = cpol ^ toggle_reg;

  // Half-bit and edge counters; everything parks at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      toggle_reg   <= 1'b0;
    end else if (!enable) begin
      half_cnt_reg <= '0;
      edge_cnt_reg <= '0;
      toggle_reg   <= 1'b0;
    end else if (edge_stb) begin
      half_cnt_reg <= '0;
      edge_cnt_reg <= done ? '0 : edge_cnt_reg + EDGE_W'(1);
      toggle_reg   <= ~toggle_reg;
    end else begin
      half_cnt_reg <= half_cnt_reg + HALF_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: accepts one word over a valid/ready handshake,
// frames it with programmable CS setup/hold/idle timing and returns the word
// received on MISO with a one-cycle valid pulse.
module spi_master_param
  import spi_pkg::*;
#(
  parameter  int DATA_W            = 12,
  parameter  int SPI_MODE          = 0,
  parameter  int CLKS_PER_HALF_BIT = 2,
  parameter  int NUM_CS            = 2,
  parameter  int CS_SETUP_CLKS     = 1,
  parameter  int CS_HOLD_CLKS      = 1,
  parameter  int CS_IDLE_CLKS      = 2,
  localparam int CS_W              = cs_width(NUM_CS)
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [DATA_W-1:0] i_TX_Data,
  input  logic [CS_W-1:0]   i_TX_CS,
  input  logic              i_TX_DV,
  output logic              o_TX_Ready,
  output logic [DATA_W-1:0] o_RX_Data,
  output logic              o_RX_DV,
  output logic              o_Busy,
  output logic              o_SPI_Clk,
  input  logic              i_SPI_MISO,
  output logic              o_SPI_MOSI,
  output logic [NUM_CS-1:0] o_SPI_CS_n
);

  localparam logic CPOL      = spi_cpol(SPI_MODE);
  localparam logic CPHA      = spi_cpha(SPI_MODE);
  localparam int   TIMER_MAX = max3(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS);
  localparam int   TIMER_W   = cnt_width(TIMER_MAX);
  localparam logic [TIMER_W-1:0] SETUP_LAST = TIMER_W'(CS_SETUP_CLKS - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(CS_HOLD_CLKS - 1);
  localparam logic [TIMER_W-1:0] IDLE_LAST  = TIMER_W'(CS_IDLE_CLKS - 1);

  generate
    if (!params_ok(DATA_W, SPI_MODE, CLKS_PER_HALF_BIT, NUM_CS,
                   CS_SETUP_CLKS, CS_HOLD_CLKS, CS_IDLE_CLKS)) begin : g_param_err
      $error("spi_master_param: parameter outside its legal range");
    end
  endgenerate

  spi_state_t        state_reg, state_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [DATA_W-1:0] tx_reg, tx_next, tx_shl;
  logic [DATA_W-1:0] rx_reg, rx_next, rx_shl;
  logic [DATA_W-1:0] rx_data_reg, rx_data_next;
  logic [CS_W-1:0]   cs_idx_reg, cs_idx_next;
  logic [NUM_CS-1:0] cs_n_reg, cs_n_next;
  logic              mosi_reg, mosi_next;
  logic              rx_dv_reg, rx_dv_next;
  logic              cs_active_next;
  logic              sclk_en, lead_edge, trail_edge, sclk_done;

  assign sclk_en = (state_reg == ST_SHIFT);
  assign tx_shl  = tx_reg << 1;
  assign rx_shl  = (rx_reg << 1) | DATA_W'(i_SPI_MISO);

  spi_sclk_gen #(
    .DATA_W            (DATA_W),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
  ) u_sclk_gen (
    .clk        (i_Clk),
    .rst        (i_Rst),
    .enable     (sclk_en),
    .cpol       (CPOL),
    .sclk       (o_SPI_Clk),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .done       (sclk_done)
  );

  // Next-state, phase timer and shift-register updates.
  always_comb begin
    state_next   = state_reg;
    timer_next   = timer_reg;
    tx_next      = tx_reg;
    rx_next      = rx_reg;
    rx_data_next = rx_data_reg;
    cs_idx_next  = cs_idx_reg;
    mosi_next    = mosi_reg;
    rx_dv_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        timer_next = '0;
        if (i_TX_DV) begin
          state_next  = ST_CS_SETUP;
          tx_next     = i_TX_Data;
          cs_idx_next = i_TX_CS;
          rx_next     = '0;
          // CPHA=0 slaves sample on the first edge, so MSB must be present during setup.
          mosi_next   = CPHA ? 1'b0 : i_TX_Data[DATA_W-1];
        end
      end
      ST_CS_SETUP: begin
        if (timer_reg == SETUP_LAST) begin
          state_next = ST_SHIFT;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end
      ST_SHIFT: begin
        if (lead_edge) begin
          if (CPHA) begin
            mosi_next = tx_reg[DATA_W-1];
            tx_next   = tx_shl;
          end else begin
            rx_next = rx_shl;
          end
        end
        if (trail_edge) begin
          if (CPHA) begin
            rx_next = rx_shl;
          end else if (!sclk_done) begin
            // Present the next bit; the final trailing edge has nothing left to send.
            mosi_next = tx_shl[DATA_W-1];
            tx_next   = tx_shl;
          end
        end
        if (sclk_done) begin
          state_next = ST_CS_HOLD;
          timer_next = '0;
        end
      end
      ST_CS_HOLD: begin
        if (timer_reg == HOLD_LAST) begin
          state_next   = ST_CS_IDLE;
          timer_next   = '0;
          rx_dv_next   = 1'b1;
          rx_data_next = rx_reg;
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end
      ST_CS_IDLE: begin
        if (timer_reg == IDLE_LAST) begin
          state_next = ST_IDLE;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + TIMER_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        timer_next = '0;
      end
    endcase
  end

  // Chip-select decode from the next state so the CS lines come straight off flops;
  // an index with no matching line leaves every CS deasserted.
  assign cs_active_next = (state_next == ST_CS_SETUP) ||
                          (state_next == ST_SHIFT)    ||
                          (state_next == ST_CS_HOLD);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
      assign cs_n_next[gi] = !(cs_active_next && (cs_idx_next == CS_W'(gi)));
    end
  endgenerate

  // State and datapath registers; reset aborts any transfer immediately.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_reg   <= ST_IDLE;
      timer_reg   <= '0;
      tx_reg      <= '0;
      rx_reg      <= '0;
      rx_data_reg <= '0;
      cs_idx_reg  <= '0;
      cs_n_reg    <= '1;
      mosi_reg    <= 1'b0;
      rx_dv_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      timer_reg   <= timer_next;
      tx_reg      <= tx_next;
      rx_reg      <= rx_next;
      rx_data_reg <= rx_data_next;
      cs_idx_reg  <= cs_idx_next;
      cs_n_reg    <= cs_n_next;
      mosi_reg    <= mosi_next;
      rx_dv_reg   <= rx_dv_next;
    end
  end

  assign o_TX_Ready = (state_reg == ST_IDLE);
  assign o_Busy     = (state_reg != ST_IDLE);
  assign o_RX_Data  = rx_data_reg;
  assign o_RX_DV    = rx_dv_reg;
  assign o_SPI_MOSI = mosi_reg;
  assign o_SPI_CS_n = cs_n_reg;

endmodule

// File: tb/tb_spi_master_param.sv
// Directed bench for spi_master_param: four configurations share one clock,
// reset and stimulus bus; a mux selects which instance is being observed.
module tb_spi_master_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  int          sel;
  logic [31:0] drv_data;
  logic [1:0]  drv_cs;
  logic        drv_dv;
  int          n_cmp = 0;
  int          n_err = 0;

  // Instance A: defaults (mode 0, 12 bit, 2 CS), MOSI looped to MISO.
  logic a_ready, a_busy, a_rx_dv, a_sclk, a_mosi;
  logic [11:0] a_rx_data;
  logic [1:0]  a_cs_n;
  spi_master_param u_a (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Data(drv_data[11:0]), .i_TX_CS(drv_cs[0]),
    .i_TX_DV(drv_dv && (sel == 0)), .o_TX_Ready(a_ready), .o_RX_Data(a_rx_data),
    .o_RX_DV(a_rx_dv), .o_Busy(a_busy), .o_SPI_Clk(a_sclk), .i_SPI_MISO(a_mosi),
    .o_SPI_MOSI(a_mosi), .o_SPI_CS_n(a_cs_n));

  // Instance B: mode 3, MISO from a slave model that returns 0x3F1.
  logic b_ready, b_busy, b_rx_dv, b_sclk, b_mosi;
  logic b_miso = 1'b0;
  logic [11:0] b_rx_data;
  logic [1:0]  b_cs_n;
  logic [11:0] slave_sr = '0;
  spi_master_param #(.SPI_MODE(3)) u_b (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Data(drv_data[11:0]), .i_TX_CS(drv_cs[0]),
    .i_TX_DV(drv_dv && (sel == 1)), .o_TX_Ready(b_ready), .o_RX_Data(b_rx_data),
    .o_RX_DV(b_rx_dv), .o_Busy(b_busy), .o_SPI_Clk(b_sclk), .i_SPI_MISO(b_miso),
    .o_SPI_MOSI(b_mosi), .o_SPI_CS_n(b_cs_n));

  // Mode-3 slave on CS 1: loads its word when selected, shifts out on falling edges.
  always @(negedge b_cs_n[1]) slave_sr = 12'h3F1;
  always @(negedge b_sclk) begin
    if (!b_cs_n[1]) begin
      b_miso   = slave_sr[11];
      slave_sr = slave_sr << 1;
    end
  end

  // Instance C: three chip-selects, loopback.
  logic c_ready, c_busy, c_rx_dv, c_sclk, c_mosi;
  logic [11:0] c_rx_data;
  logic [2:0]  c_cs_n;
  spi_master_param #(.NUM_CS(3)) u_c (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Data(drv_data[11:0]), .i_TX_CS(drv_cs),
    .i_TX_DV(drv_dv && (sel == 2)), .o_TX_Ready(c_ready), .o_RX_Data(c_rx_data),
    .o_RX_DV(c_rx_dv), .o_Busy(c_busy), .o_SPI_Clk(c_sclk), .i_SPI_MISO(c_mosi),
    .o_SPI_MOSI(c_mosi), .o_SPI_CS_n(c_cs_n));

  // Instance D: 16 bit, 4 clocks per half bit, mode 1, loopback.
  logic d_ready, d_busy, d_rx_dv, d_sclk, d_mosi;
  logic [15:0] d_rx_data;
  logic [1:0]  d_cs_n;
  spi_master_param #(.DATA_W(16), .SPI_MODE(1), .CLKS_PER_HALF_BIT(4)) u_d (
    .i_Clk(clk), .i_Rst(rst), .i_TX_Data(drv_data[15:0]), .i_TX_CS(drv_cs[0]),
    .i_TX_DV(drv_dv && (sel == 3)), .o_TX_Ready(d_ready), .o_RX_Data(d_rx_data),
    .o_RX_DV(d_rx_dv), .o_Busy(d_busy), .o_SPI_Clk(d_sclk), .i_SPI_MISO(d_mosi),
    .o_SPI_MOSI(d_mosi), .o_SPI_CS_n(d_cs_n));

  // Observation mux; CS buses are padded to 3 bits with inactive ones.
  logic        mon_ready, mon_busy, mon_rx_dv, mon_sclk, mon_mosi;
  logic [31:0] mon_rx_data;
  logic [2:0]  mon_cs_n;
  always_comb begin
    mon_ready = 1'b0; mon_busy = 1'b0; mon_rx_dv = 1'b0; mon_sclk = 1'b0;
    mon_mosi = 1'b0; mon_rx_data = '0; mon_cs_n = 3'b111;
    case (sel)
      0: begin mon_ready = a_ready; mon_busy = a_busy; mon_rx_dv = a_rx_dv; mon_sclk = a_sclk;
               mon_mosi = a_mosi; mon_rx_data = 32'(a_rx_data); mon_cs_n = {1'b1, a_cs_n}; end
      1: begin mon_ready = b_ready; mon_busy = b_busy; mon_rx_dv = b_rx_dv; mon_sclk = b_sclk;
               mon_mosi = b_mosi; mon_rx_data = 32'(b_rx_data); mon_cs_n = {1'b1, b_cs_n}; end
      2: begin mon_ready = c_ready; mon_busy = c_busy; mon_rx_dv = c_rx_dv; mon_sclk = c_sclk;
               mon_mosi = c_mosi; mon_rx_data = 32'(c_rx_data); mon_cs_n = c_cs_n; end
      default: begin mon_ready = d_ready; mon_busy = d_busy; mon_rx_dv = d_rx_dv; mon_sclk = d_sclk;
               mon_mosi = d_mosi; mon_rx_data = 32'(d_rx_data); mon_cs_n = {1'b1, d_cs_n}; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transfer observations (index = cycle number, cycle 1 = first after accept).
  int          dv_cycles[$];
  logic [31:0] dv_data[$];
  logic [2:0]  cs_hist[$];
  logic        rdy_hist[$];
  int          first_ready, first_tog, toggles, mosi_rise, mosi_fall, mosi_other;
  logic        cs_low_seen, sclk_c1, mosi_c1;

  // Raise DV for instance s at a falling edge, then sample every falling edge
  // for ncyc cycles. data2 replaces the data bus after cycle 1; DV drops after dv_drop.
  task automatic xfer(input int s, input logic [31:0] data, input logic [31:0] data2,
                      input logic [1:0] cs, input int ncyc, input int dv_drop);
    logic p_sclk, p_mosi;
    dv_cycles.delete(); dv_data.delete(); cs_hist.delete(); rdy_hist.delete();
    first_ready = -1; first_tog = -1; toggles = 0;
    mosi_rise = 0; mosi_fall = 0; mosi_other = 0; cs_low_seen = 1'b0;
    @(negedge clk);
    sel = s; drv_data = data; drv_cs = cs; drv_dv = 1'b1;
    #1;
    p_sclk = mon_sclk; p_mosi = mon_mosi;
    cs_hist.push_back(mon_cs_n); rdy_hist.push_back(mon_ready);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) begin sclk_c1 = mon_sclk; mosi_c1 = mon_mosi; drv_data = data2; end
      if (mon_sclk != p_sclk) begin
        toggles++;
        if (first_tog < 0) first_tog = k;
      end
      if (k >= 2 && mon_mosi != p_mosi) begin
        if (mon_sclk && !p_sclk) mosi_rise++;
        else if (!mon_sclk && p_sclk) mosi_fall++;
        else mosi_other++;
      end
      if (mon_rx_dv) begin dv_cycles.push_back(k); dv_data.push_back(mon_rx_data); end
      if (mon_ready && first_ready < 0) first_ready = k;
      if (mon_cs_n != 3'b111) cs_low_seen = 1'b1;
      cs_hist.push_back(mon_cs_n);
      rdy_hist.push_back(mon_ready);
      p_sclk = mon_sclk; p_mosi = mon_mosi;
      if (k == dv_drop) drv_dv = 1'b0;
    end
    $display("xfer inst=%0d data=0x%0h cs=%0d: toggles=%0d rx_dv=%0d ready@%0d",
             s, data, cs, toggles, dv_cycles.size(), first_ready);
  endtask

  // Checks one expected RX_DV pulse; a missing pulse counts as a failed comparison.
  task automatic check_dv(input string tag, input int idx, input int exp_cyc,
                          input logic [31:0] exp_data);
    if (dv_cycles.size() > idx) begin
      check({tag, "_dv_cycle"}, 32'(dv_cycles[idx]), 32'(exp_cyc));
      check({tag, "_rx_data"}, dv_data[idx], exp_data);
    end else begin
      check({tag, "_dv_missing"}, 32'(dv_cycles.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    sel = 0; drv_data = '0; drv_cs = '0; drv_dv = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_ready",   32'(mon_ready), 32'd1);
    check("rst_busy",    32'(mon_busy), 32'd0);
    check("rst_rx_dv",   32'(mon_rx_dv), 32'd0);
    check("rst_rx_data", mon_rx_data, 32'h0);
    check("rst_sclk",    32'(mon_sclk), 32'd0);
    check("rst_mosi",    32'(mon_mosi), 32'd0);
    check("rst_cs_n",    32'(mon_cs_n), 32'h7);
    check("rst_b_sclk",  32'(b_sclk), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Mode 0 loopback, 0xA5C on CS 0.
    xfer(0, 32'hA5C, 32'hA5C, 2'd0, 53, 1);
    check("m0_cs_c1",      32'(cs_hist[1]), 32'h6);
    check("m0_mosi_c1",    32'(mosi_c1), 32'd1);
    check("m0_sclk_c1",    32'(sclk_c1), 32'd0);
    check("m0_first_tog",  32'(first_tog), 32'd4);
    check("m0_toggles",    32'(toggles), 32'd24);
    check("m0_mosi_rise",  32'(mosi_rise), 32'd0);
    check("m0_mosi_other", 32'(mosi_other), 32'd0);
    check("m0_dv_count",   32'(dv_cycles.size()), 32'd1);
    check_dv("m0", 0, 51, 32'hA5C);
    check("m0_cs_c50",     32'(cs_hist[50]), 32'h6);
    check("m0_cs_c51",     32'(cs_hist[51]), 32'h7);
    check("m0_ready_c52",  32'(rdy_hist[52]), 32'd0);
    check("m0_ready_at",   32'(first_ready), 32'd53);

    // Mode 3, slave returns 0x3F1, master sends 0x000 on CS 1.
    xfer(1, 32'h000, 32'h000, 2'd1, 53, 1);
    check("m3_sclk_c1",   32'(sclk_c1), 32'd1);
    check("m3_cs_c1",     32'(cs_hist[1]), 32'h5);
    check("m3_cs_c30",    32'(cs_hist[30]), 32'h5);
    check("m3_toggles",   32'(toggles), 32'd24);
    check("m3_mosi_rise", 32'(mosi_rise), 32'd0);
    check("m3_dv_count",  32'(dv_cycles.size()), 32'd1);
    check_dv("m3", 0, 51, 32'h3F1);
    check("m3_ready_at",  32'(first_ready), 32'd53);
    check("m3_sclk_end",  32'(mon_sclk), 32'd1);

    // DV held high: 0x123 then 0x456; DV during the first transfer is ignored.
    xfer(0, 32'h123, 32'h456, 2'd0, 106, 60);
    check("b2b_dv_count", 32'(dv_cycles.size()), 32'd2);
    check_dv("b2b_1", 0, 51, 32'h123);
    check_dv("b2b_2", 1, 104, 32'h456);
    check("b2b_ready_at", 32'(first_ready), 32'd53);
    check("b2b_ready_54", 32'(rdy_hist[54]), 32'd0);
    check("b2b_ready_106", 32'(rdy_hist[106]), 32'd1);

    // Reset pulsed at cycle 20, mid-shift.
    xfer(0, 32'hA5C, 32'hA5C, 2'd0, 20, 1);
    check("rmid_busy_pre", 32'(mon_busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rmid_cs_n",  32'(mon_cs_n), 32'h7);
    check("rmid_sclk",  32'(mon_sclk), 32'd0);
    check("rmid_ready", 32'(mon_ready), 32'd1);
    check("rmid_rx_dv", 32'(mon_rx_dv), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    xfer(0, 32'h5A3, 32'h5A3, 2'd0, 53, 1);
    check("rpost_dv_count", 32'(dv_cycles.size()), 32'd1);
    check_dv("rpost", 0, 51, 32'h5A3);

    // Three CS lines, index 3 selects none; timing still runs.
    xfer(2, 32'h7E1, 32'h7E1, 2'd3, 53, 1);
    check("cs3_low_seen", 32'(cs_low_seen), 32'd0);
    check("cs3_toggles",  32'(toggles), 32'd24);
    check_dv("cs3", 0, 51, 32'h7E1);
    check("cs3_ready_at", 32'(first_ready), 32'd53);

    // 16 bit, 4 clocks per half bit, mode 1, loopback 0xBEEF.
    xfer(3, 32'hBEEF, 32'hBEEF, 2'd0, 133, 1);
    check("w16_cs_c1",      32'(cs_hist[1]), 32'h6);
    check("w16_first_tog",  32'(first_tog), 32'd6);
    check("w16_toggles",    32'(toggles), 32'd32);
    check("w16_mosi_fall",  32'(mosi_fall), 32'd0);
    check("w16_mosi_other", 32'(mosi_other), 32'd0);
    check("w16_dv_count",   32'(dv_cycles.size()), 32'd1);
    check_dv("w16", 0, 131, 32'hBEEF);
    check("w16_ready_at",   32'(first_ready), 32'd133);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
Parametrised SPI master, successor to the fixed 12-bit master. Generalises word width, SPI mode (CPOL/CPHA), SCLK divide ratio and number of chip-selects. Adds programmable CS setup, hold and idle timing. Sits between a sampling/control FSM (valid/ready handshake) and external SPI ADC/DAC devices.

Parameters:
DATA_W, 12, bits per transfer, 1..32, MSB first
SPI_MODE, 0, 0..3; CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
CLKS_PER_HALF_BIT, 2, i_Clk cycles per SCLK half-period, >= 2
NUM_CS, 2, number of active-low chip-selects, >= 1
CS_SETUP_CLKS, 1, cycles from CS low to start of SHIFT, >= 1
CS_HOLD_CLKS, 1, cycles from last SCLK edge to CS high, >= 1
CS_IDLE_CLKS, 2, minimum CS-high cycles before next accept, >= 1

Ports:
i_Clk  in  1  system clock
i_Rst  in  1  asynchronous reset, active-high
i_TX_Data  in  DATA_W  word to shift out
i_TX_CS  in  CS_W = max(1, clog2(NUM_CS))  target chip-select index
i_TX_DV  in  1  request valid
o_TX_Ready  out  1  ready to accept
o_RX_Data  out  DATA_W  last received word
o_RX_DV  out  1  one-cycle pulse, o_RX_Data valid
o_Busy  out  1  transaction in progress (state != IDLE)
o_SPI_Clk  out  1  SCLK
i_SPI_MISO  in  1  serial in
o_SPI_MOSI  out  1  serial out
o_SPI_CS_n  out  NUM_CS  chip-selects, active-low

Behaviour:
- Reset values (async, immediate): state IDLE, o_TX_Ready=1, o_Busy=0, o_RX_DV=0, o_RX_Data=0, o_SPI_Clk=CPOL, o_SPI_MOSI=0, o_SPI_CS_n=all 1.
- Accept on the rising edge where i_TX_DV && o_TX_Ready (cycle 0). Latch data and CS index. o_TX_Ready=0 from cycle 1. i_TX_DV while not ready is ignored; there is no queue.
- States: IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> CS_IDLE -> IDLE.
- CS_SETUP: selected CS low from cycle 1. Lasts CS_SETUP_CLKS cycles. For CPHA=0, MOSI = data MSB during CS_SETUP.
- SHIFT: lasts 2*DATA_W*CLKS_PER_HALF_BIT cycles, producing exactly 2*DATA_W SCLK toggles. The first toggle occurs CLKS_PER_HALF_BIT cycles after entering SHIFT; the last toggle ends the state.
- CPHA=0: sample MISO on leading edges; update MOSI on trailing edges (none after the final edge).
- CPHA=1: update MOSI on leading edges (first leading edge drives MSB); sample MISO on trailing edges.
- CS_HOLD: SCLK at CPOL, CS still low, for CS_HOLD_CLKS cycles.
- On exit from CS_HOLD, in the same cycle: CS goes high, o_RX_DV=1 for exactly one cycle, o_RX_Data updated. o_RX_Data holds until the next completion.
- CS_IDLE: lasts CS_IDLE_CLKS cycles, then IDLE with o_TX_Ready=1.
- Accept-to-ready latency: 1 + CS_SETUP_CLKS + 2*DATA_W*CLKS_PER_HALF_BIT + CS_HOLD_CLKS + CS_IDLE_CLKS. With defaults this is 53 cycles: o_RX_DV at cycle 51, ready at cycle 53.
- i_TX_CS >= NUM_CS: no CS asserted, but the full timing still runs and o_RX_DV still pulses.
- i_TX_DV held high continuously: back-to-back transfers are spaced exactly by the latency above.
- Reset mid-transaction: abort immediately, all outputs to reset values, no o_RX_DV.
- Elaboration-time error on any parameter outside its stated range.

Decomposition:
- Package spi_pkg: state enum, CPOL/CPHA extract functions, CS_W width function, parameter range-check macro/function.
- Sub-module spi_sclk_gen:
  - inputs: enable, CPOL.
  - outputs: o_SPI_Clk, leading-edge strobe, trailing-edge strobe, done after 2*DATA_W edges.
  - Contains the half-bit counter and edge counter.
- The parent owns the FSM, shift registers and CS decode.

Test Plan:
- Mode 0 defaults, MOSI looped to MISO, send 0xA5C on CS 0 -> CS_n=2'b10 from cycle 1; 24 SCLK toggles, idle low; o_RX_DV at cycle 51 with o_RX_Data=0xA5C; CS_n=2'b11 at cycle 51; ready at cycle 53.
- Mode 3, slave model returns 0x3F1, send 0x000 on CS 1 -> SCLK idles high; MOSI changes only on falling edges; RX 0x3F1; CS_n=2'b01 during transfer.
- i_TX_DV held high with 0x123 then 0x456 -> two transfers; second accepted at cycle 53; both RX_DV pulses single-cycle; DV asserted during the first transfer is ignored.
- i_Rst pulsed at cycle 20 (mid-SHIFT) -> CS_n=2'b11, SCLK=CPOL, ready=1 within the reset assertion; no RX_DV; a fresh transfer afterwards completes with the correct data.
- NUM_CS=3, i_TX_CS=3 -> no CS_n bit low; RX_DV still at cycle 51.
- DATA_W=16, CLKS_PER_HALF_BIT=4, mode 1, loopback 0xBEEF -> 32 toggles over 128 SHIFT cycles; RX 0xBEEF; ready at cycle 1+1+128+1+2=133.
